// File: rtl/stack_ctrl.sv
// stack_ctrl: register-array LIFO with combinational top-of-stack decode and overflow/underflow flags.
// Optional macro STACK_ERR_STICKY_EN: error flags latch until reset instead of pulsing for one cycle.
module stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tos,
    output logic              tos_zero,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     sp_q, sp_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [AW-1:0]     top_idx;
    logic              ovf_evt, udf_evt;

    // Status decode straight from the pointer and array.
    always_comb begin
        empty    = (sp_q == '0);
        full     = (sp_q == CW'(DEPTH));
        count    = sp_q;
        top_idx  = AW'(sp_q - CW'(1));
        tos      = empty ? '0 : mem_q[top_idx];
        tos_zero = !empty && (tos == '0);
    end

    always_comb begin
        mem_d   = mem_q;
        sp_d    = sp_q;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    mem_d[AW'(sp_q)] = din;
                    sp_d             = sp_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty) udf_evt = 1'b1;
                else       sp_d    = sp_q - CW'(1);
            end
            2'b11: begin
                // Simultaneous push/pop replaces the top; on an empty stack only the push lands.
                if (empty) begin
                    mem_d[0] = din;
                    sp_d     = CW'(1);
                    udf_evt  = 1'b1;
                end else begin
                    mem_d[top_idx] = din;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
`ifdef STACK_ERR_STICKY_EN
        overflow_d  = overflow_q | ovf_evt;
        underflow_d = underflow_q | udf_evt;
`else
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;
`endif
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Array is not cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset) mem_q <= mem_d;
    end

endmodule
